caliptra_apb_arbiter: RTL
=========================

Name: caliptra_apb_arbiter

Overview:
Two-requester APB arbiter in the FPGA wrapper. It shares the single Caliptra SoC APB target (the PADDR/PAUSER/PRDATA bus into the wrapper) between the host AXI-to-APB bridge (port 0) and a debug/test APB driver (port 1). Arbitration is round-robin, one transfer per grant, with a downstream-hang timeout. Each transfer carries its own requester's PAUSER, so mailbox user filtering still sees the true requester.

Parameters:
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width
USER_WIDTH, 32, PAUSER width
TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; 0 disables the timeout

Ports:
core_clk  in  1  sole clock
core_rst_b  in  1  synchronous active-low reset, sampled on the core_clk rising edge
sN_paddr (N=0,1)  in  ADDR_WIDTH  upstream address
sN_pprot  in  3  upstream protection
sN_pauser  in  USER_WIDTH  upstream user ID
sN_psel / sN_penable / sN_pwrite  in  1 each  upstream APB control
sN_pwdata  in  DATA_WIDTH  upstream write data
sN_prdata  out  DATA_WIDTH  upstream read data
sN_pready / sN_pslverr  out  1 each  upstream completion
m_paddr / m_pprot / m_pauser / m_pwrite / m_pwdata  out  as above  downstream request, registered
m_psel / m_penable  out  1 each  downstream control
m_prdata  in  DATA_WIDTH  downstream read data
m_pready / m_pslverr  in  1 each  downstream completion
grant_id  out  1  port currently owning or last owning the bus
timeout_count  out  8  saturating count of timed-out transfers

Behaviour:
- Reset (core_rst_b=0 at an edge): state=IDLE; all outputs 0; last_grant=1, so port 0 wins first. Reset mid-transfer drops m_psel and m_penable on the same edge, with no upstream response.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - A request is sN_psel=1.
  - One requester: grant it.
  - Both requesting: grant the port != last_grant.
  - On grant: latch paddr, pprot, pauser, pwrite, pwdata; set grant_id; go to SETUP.
- SETUP (1 cycle): m_psel=1, m_penable=0.
- ACCESS: m_psel=1, m_penable=1; the cycle counter increments each cycle.
  - m_pready=1: capture m_prdata and m_pslverr; go to RESP.
  - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort.
    - Abort response: prdata=0, pslverr=1.
    - timeout_count increments, saturating at 8'hFF.
    - Go to RESP.
  - m_pready on the timeout cycle: completion wins and no timeout is counted.
- RESP (1 cycle): m_psel=0, m_penable=0.
  - Granted port gets pready=1 with the captured prdata/pslverr, only if its sN_psel is still 1. If sN_psel has dropped, the response is discarded.
  - last_grant <= grant_id; go to IDLE.
- Non-granted port: pready=0, prdata=0, pslverr=0 at all times. Its request waits; it wins the next IDLE.
- sN_pready is high for exactly one cycle per transfer; prdata and pslverr are 0 whenever pready=0.
- Write response: prdata=0. m_pwdata is driven only while m_pwrite=1 and is 0 otherwise.
- Latency: psel seen at edge N → m_psel at N+1 → m_penable at N+2. With m_pready=1 at N+2, sN_pready=1 at N+3.
- Back-to-back: IDLE costs one cycle, so minimum downstream spacing is 4 cycles.
- The other port's request present in RESP is granted in the next IDLE, giving strict alternation under contention.
- Upstream sN_penable is ignored; requesters are assumed APB-compliant. Upstream address/data are ignored after latching.

Test Plan:
- Single read, port 0, paddr=32'h3002_0000, m_pready=1 in the first ACCESS cycle, m_prdata=32'hCAFE_F00D → s0_pready=1 at N+3 with s0_prdata=32'hCAFE_F00D and s0_pslverr=0; m_pauser equals s0_pauser.
- Both ports request in the same cycle after reset → port 0 served first, then port 1. grant_id sequence 0,1. Repeat 10 times → 5 transfers per port, strictly alternating.
- Write from port 1 with 3 m_pready wait states → m_pwdata stable through ACCESS; s1_pready asserted exactly once, 1 cycle after m_pready.
- m_pready held 0, TIMEOUT_CYCLES=16 → m_penable high for exactly 16 cycles; s0_pslverr=1 and s0_prdata=0; timeout_count=1. Repeat 300 times → timeout_count stays 8'hFF.
- m_pslverr=1 with m_pready → pslverr forwarded to the granted port only; the other port sees 0.
- Assert core_rst_b=0 during ACCESS → next edge m_psel=0, no sN_pready. After release, a port-0 request is granted first.

Source files
------------

// File: rtl/caliptra_apb_arbiter.sv
// caliptra_apb_arbiter
//   Shares the single Caliptra SoC APB target between two upstream APB
//   requesters (port 0: host AXI-to-APB bridge, port 1: debug/test driver).
//   Round-robin, one transfer per grant, with an optional downstream-hang
//   timeout. The granted requester's PAUSER is forwarded with its transfer.
//
// Ports
//   core_clk, core_rst_b      clock, synchronous active-low reset
//   sN_* (N=0,1)              upstream APB target ports (penable ignored)
//   m_*                       downstream APB requester port (registered)
//   grant_id                  port currently owning / last owning the bus
//   timeout_count             saturating count of timed-out transfers
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; arbitrate between pending requests
// SETUP  | downstream APB setup phase (psel=1, penable=0)
// ACCESS | downstream APB access phase; waits for pready or timeout
// RESP   | one-cycle completion pulse to the granted requester
module caliptra_apb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int USER_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  core_clk,
    input  logic                  core_rst_b,

    input  logic [ADDR_WIDTH-1:0] s0_paddr,
    input  logic [2:0]            s0_pprot,
    input  logic [USER_WIDTH-1:0] s0_pauser,
    input  logic                  s0_psel,
    input  logic                  s0_penable,
    input  logic                  s0_pwrite,
    input  logic [DATA_WIDTH-1:0] s0_pwdata,
    output logic [DATA_WIDTH-1:0] s0_prdata,
    output logic                  s0_pready,
    output logic                  s0_pslverr,

    input  logic [ADDR_WIDTH-1:0] s1_paddr,
    input  logic [2:0]            s1_pprot,
    input  logic [USER_WIDTH-1:0] s1_pauser,
    input  logic                  s1_psel,
    input  logic                  s1_penable,
    input  logic                  s1_pwrite,
    input  logic [DATA_WIDTH-1:0] s1_pwdata,
    output logic [DATA_WIDTH-1:0] s1_prdata,
    output logic                  s1_pready,
    output logic                  s1_pslverr,

    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [2:0]            m_pprot,
    output logic [USER_WIDTH-1:0] m_pauser,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic [DATA_WIDTH-1:0] m_prdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,

    output logic                  grant_id,
    output logic [7:0]            timeout_count
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  grant_nxt;
    logic                  win;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [7:0]            tc_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [2:0]            pprot_nxt;
    logic [USER_WIDTH-1:0] pauser_nxt;
    logic                  pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  s0_pready_nxt, s1_pready_nxt;

    // Upstream penable carries no information for this arbiter.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_id;
        win            = 1'b0;
        cnt_nxt        = cnt;
        tc_nxt         = timeout_count;
        paddr_nxt      = m_paddr;
        pprot_nxt      = m_pprot;
        pauser_nxt     = m_pauser;
        pwrite_nxt     = m_pwrite;
        pwdata_nxt     = m_pwdata;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_err        = 1'b0;

        unique case (state)
            IDLE: begin
                if (s0_psel || s1_psel) begin
                    // Contention goes to the port that did not win last time.
                    win        = (s0_psel && s1_psel) ? ~last_grant : s1_psel;
                    grant_nxt  = win;
                    paddr_nxt  = win ? s1_paddr  : s0_paddr;
                    pprot_nxt  = win ? s1_pprot  : s0_pprot;
                    pauser_nxt = win ? s1_pauser : s0_pauser;
                    pwrite_nxt = win ? s1_pwrite : s0_pwrite;
                    // Write data is only presented for writes.
                    if (win ? s1_pwrite : s0_pwrite) begin
                        pwdata_nxt = win ? s1_pwdata : s0_pwdata;
                    end else begin
                        pwdata_nxt = '0;
                    end
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                cnt_nxt = cnt + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (m_pready) begin
                    rsp_valid = 1'b1;
                    rsp_data  = m_pwrite ? '0 : m_prdata;
                    rsp_err   = m_pslverr;
                    state_nxt = RESP;
                end else if (TIMEOUT_EN && (cnt == TC_LAST)) begin
                    rsp_valid = 1'b1;
                    rsp_data  = '0;
                    rsp_err   = 1'b1;
                    tc_nxt    = (timeout_count == 8'hFF) ? 8'hFF : timeout_count + 8'd1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                last_grant_nxt = grant_id;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A requester that dropped psel before completion gets no response.
    assign s0_pready_nxt = rsp_valid && (grant_id == 1'b0) && s0_psel;
    assign s1_pready_nxt = rsp_valid && (grant_id == 1'b1) && s1_psel;

    always_ff @(posedge core_clk) begin
        if (!core_rst_b) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            cnt           <= '0;
            timeout_count <= 8'h00;
            m_paddr       <= '0;
            m_pprot       <= '0;
            m_pauser      <= '0;
            m_pwrite      <= 1'b0;
            m_pwdata      <= '0;
            m_psel        <= 1'b0;
            m_penable     <= 1'b0;
            s0_pready     <= 1'b0;
            s0_prdata     <= '0;
            s0_pslverr    <= 1'b0;
            s1_pready     <= 1'b0;
            s1_prdata     <= '0;
            s1_pslverr    <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            grant_id      <= grant_nxt;
            cnt           <= cnt_nxt;
            timeout_count <= tc_nxt;
            m_paddr       <= paddr_nxt;
            m_pprot       <= pprot_nxt;
            m_pauser      <= pauser_nxt;
            m_pwrite      <= pwrite_nxt;
            m_pwdata      <= pwdata_nxt;
            m_psel        <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            m_penable     <= (state_nxt == ACCESS);
            s0_pready     <= s0_pready_nxt;
            s0_prdata     <= s0_pready_nxt ? rsp_data : '0;
            s0_pslverr    <= s0_pready_nxt && rsp_err;
            s1_pready     <= s1_pready_nxt;
            s1_prdata     <= s1_pready_nxt ? rsp_data : '0;
            s1_pslverr    <= s1_pready_nxt && rsp_err;
        end
    end

endmodule
